mod_updown_counter: RTL and testbench

Parametrised up/down counter with programmable modulus, variable step, and selectable wrap or saturate behaviour. It replaces the fixed-step binary counter wherever a bounded range is needed: link-training timeouts, credit and occupancy tracking, and lane-deskew pointers in the LVDS transceiver. It provides registered overflow/underflow event pulses and an optional threshold comparator.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_next_calc.sv | 77 +++++++
 rtl/mod_updown_counter.sv | 112 +++++++++++
 tb/tb_mod_updown_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter: wrap/saturate mode and the 2-bit op code.
package counter_pkg;

    localparam logic CNT_MODE_WRAP = 1'b0;
    localparam logic CNT_MODE_SAT  = 1'b1;

    // Clear is issued as LOAD with a zero load value.
    typedef enum logic [1:0] {
        CNT_OP_HOLD = 2'd0,
        CNT_OP_UP   = 2'd1,
        CNT_OP_DOWN = 2'd2,
        CNT_OP_LOAD = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculation: bounded add/subtract with wrap or clip,
// out-of-range recovery and overflow/underflow flags.
import counter_pkg::*;

module counter_next_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH:0]   i_s,
    input  logic [WIDTH-1:0] i_limit,
    input  logic [WIDTH-1:0] i_load_val,
    input  cnt_op_e          i_op,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_ovf,
    output logic             o_unf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH:0]   w_c;
    logic [WIDTH:0]   w_l;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_dn_sub;
    logic [WIDTH-1:0] w_oor_dn;

    assign w_c   = {1'b0, i_count};
    assign w_l   = {1'b0, i_limit};
    assign w_sum = w_c + i_s;

    // The true results fit in WIDTH bits, so modulo-2^WIDTH arithmetic yields them exactly.
    assign w_up_wrap = w_sum[WIDTH-1:0] - i_limit - ONE;
    assign w_dn_wrap = i_count + i_limit + ONE - i_s[WIDTH-1:0];
    assign w_dn_sub  = i_count - i_s[WIDTH-1:0];
    assign w_oor_dn  = i_limit - i_s[WIDTH-1:0];

    always_comb begin
        o_next = i_count;
        o_ovf  = 1'b0;
        o_unf  = 1'b0;
        case (i_op)
            CNT_OP_LOAD: begin
                o_next = (i_load_val > i_limit) ? i_limit : i_load_val;
            end
            CNT_OP_UP: begin
                if (i_s != '0) begin
                    if (w_c > w_l) begin
                        o_next = i_limit;
                        o_ovf  = 1'b1;
                    end else if (w_sum > w_l) begin
                        o_next = (i_mode == CNT_MODE_SAT) ? i_limit : w_up_wrap;
                        o_ovf  = 1'b1;
                    end else begin
                        o_next = w_sum[WIDTH-1:0];
                    end
                end
            end
            CNT_OP_DOWN: begin
                if (i_s != '0) begin
                    if (w_c > w_l) begin
                        o_next = (w_l >= i_s) ? w_oor_dn : '0;
                        o_unf  = 1'b1;
                    end else if (w_c < i_s) begin
                        o_next = (i_mode == CNT_MODE_SAT) ? '0 : w_dn_wrap;
                        o_unf  = 1'b1;
                    end else begin
                        o_next = w_dn_sub;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, variable step and wrap/saturate mode.
// Optional threshold comparator (i_thresh / o_above) is enabled by defining CNT_THRESH_EN.
import counter_pkg::*;

module mod_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int SATURATE = 0
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_en,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_set,
    input  logic              i_clr,
    input  logic [WIDTH-1:0]  i_set_val,
    input  logic [WIDTH-1:0]  i_limit,
`ifdef CNT_THRESH_EN
    input  logic [WIDTH-1:0]  i_thresh,
    output logic              o_above,
`endif
    output logic [WIDTH-1:0]  o_count,
    output logic              o_max,
    output logic              o_zero,
    output logic              o_ovf,
    output logic              o_unf
);

    localparam logic           MODE = (SATURATE != 0) ? CNT_MODE_SAT : CNT_MODE_WRAP;
    localparam logic [WIDTH:0] ONE1 = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;

    cnt_op_e          w_op;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH:0]   w_range;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_s;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf;
    logic             w_unf;

    always_comb begin
        w_op       = CNT_OP_HOLD;
        w_load_val = i_set_val;
        if (i_clr) begin
            w_op       = CNT_OP_LOAD;
            w_load_val = '0;
        end else if (i_set) begin
            w_op = CNT_OP_LOAD;
        end else if (i_en && (i_inc ^ i_dec)) begin
            w_op = i_inc ? CNT_OP_UP : CNT_OP_DOWN;
        end
    end

    // A step larger than the range would wrap more than once; limit it to one full lap.
    assign w_range    = {1'b0, i_limit} + ONE1;
    assign w_step_ext = {{(WIDTH+1-STEP_W){1'b0}}, i_step};
    assign w_s        = (w_step_ext > w_range) ? w_range : w_step_ext;

    counter_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .i_count    (r_count),
        .i_s        (w_s),
        .i_limit    (i_limit),
        .i_load_val (w_load_val),
        .i_op       (w_op),
        .i_mode     (MODE),
        .o_next     (w_next),
        .o_ovf      (w_ovf),
        .o_unf      (w_unf)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

`ifdef CNT_THRESH_EN
    logic r_above;

    // Compared against the next count so the flag lands in the same cycle as o_count.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_above <= 1'b0;
        end else begin
            r_above <= (w_next >= i_thresh);
        end
    end

    assign o_above = r_above;
`endif

    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;
    assign o_max   = (r_count == i_limit);
    assign o_zero  = (r_count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a wrap and a saturate instance share stimulus;
// each vector names which instance it checks. Threshold checks need CNT_THRESH_EN.
`timescale 1ns/1ps
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       en, inc, dec, set, clr;
    logic [7:0] step, set_val, limit;
`ifdef CNT_THRESH_EN
    logic [7:0] thresh;
    logic       above_w, above_s;
`endif
    logic [7:0] cnt_w, cnt_s;
    logic       max_w, zero_w, ovf_w, unf_w;
    logic       max_s, zero_s, ovf_s, unf_s;

    int n_total  = 0;
    int n_passed = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(8), .STEP_W(8), .SATURATE(0)) u_wrap (
        .i_clk(clk), .i_arst_n(arst_n), .i_en(en), .i_inc(inc), .i_dec(dec),
        .i_step(step), .i_set(set), .i_clr(clr), .i_set_val(set_val), .i_limit(limit),
`ifdef CNT_THRESH_EN
        .i_thresh(thresh), .o_above(above_w),
`endif
        .o_count(cnt_w), .o_max(max_w), .o_zero(zero_w), .o_ovf(ovf_w), .o_unf(unf_w)
    );

    mod_updown_counter #(.WIDTH(8), .STEP_W(8), .SATURATE(1)) u_sat (
        .i_clk(clk), .i_arst_n(arst_n), .i_en(en), .i_inc(inc), .i_dec(dec),
        .i_step(step), .i_set(set), .i_clr(clr), .i_set_val(set_val), .i_limit(limit),
`ifdef CNT_THRESH_EN
        .i_thresh(thresh), .o_above(above_s),
`endif
        .o_count(cnt_s), .o_max(max_s), .o_zero(zero_s), .o_ovf(ovf_s), .o_unf(unf_s)
    );

    typedef struct {
        logic       clr, set, en, inc, dec;
        logic [7:0] step, set_val, limit;
        logic       sat;
        logic [7:0] exp_count;
        logic       exp_ovf, exp_unf, exp_max, exp_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic s, logic e, logic i, logic d,
                                logic [7:0] st, logic [7:0] sv, logic [7:0] lim,
                                logic sat, logic [7:0] cnt, logic ovf, logic unf);
        vec_t v;
        v.clr = c; v.set = s; v.en = e; v.inc = i; v.dec = d;
        v.step = st; v.set_val = sv; v.limit = lim; v.sat = sat;
        v.exp_count = cnt; v.exp_ovf = ovf; v.exp_unf = unf;
        v.exp_max  = (cnt == lim);
        v.exp_zero = (cnt == 8'd0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic drive(input vec_t v);
        clr = v.clr; set = v.set; en = v.en; inc = v.inc; dec = v.dec;
        step = v.step; set_val = v.set_val; limit = v.limit;
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [11:0] got, exp;
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        if (v.sat) got = {cnt_s, ovf_s, unf_s, max_s, zero_s};
        else       got = {cnt_w, ovf_w, unf_w, max_w, zero_w};
        exp = {v.exp_count, v.exp_ovf, v.exp_unf, v.exp_max, v.exp_zero};
        $display("vec %0d %s: count=%0d ovf=%0b unf=%0b (cnt,ovf,unf,max,zero)=0x%0h",
                 idx, v.sat ? "sat " : "wrap", got[11:4], got[3], got[2], got);
        check($sformatf("vec%0d", idx), {20'd0, got}, {20'd0, exp});
    endtask

    initial begin
        //             clr set en inc dec step  val  lim  sat cnt ovf unf
        vecs.push_back(mk(1, 0, 0, 0, 0,   0,   0,   9, 0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   3,   0,   9, 0,   3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   3,   0,   9, 0,   6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   3,   0,   9, 0,   9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   3,   0,   9, 0,   2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   3,   0,   9, 0,   5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,   0,   0,   9, 1,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,   5,   9, 1,   5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,   4,   0,   9, 1,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,   4,   0,   9, 1,   0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1,   4,   0,   9, 1,   0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1,   4,   0,   9, 1,   0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,   8,   9, 1,   8, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   4,   0,   9, 1,   9, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   4,   0,   9, 1,   9, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0,   3,  77,   9, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0, 200, 100, 0, 100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1,   3,   0, 100, 0, 100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   3,   0, 100, 0, 100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   0,   0, 100, 0, 100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   5,   0, 100, 0, 100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,   0,   0, 100, 0, 100, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,  50, 100, 0,  50, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   1,   0,  20, 0,  50, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   1,   0,  20, 0,  20, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,  25,   0,  20, 0,  20, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1,   3,   0,  20, 0,  17, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,  50, 100, 0,  50, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,   5,   0,  20, 0,  15, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,  50, 100, 0,  50, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,  30,   0,  20, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1,   3,   0,  20, 0,  18, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,   0,   0, 0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   1,   0,   0, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0, 250, 255, 0, 250, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,  10,   0, 255, 0,   4, 1, 0));

        arst_n = 1'b0;
        en = 0; inc = 0; dec = 0; set = 0; clr = 0;
        step = 0; set_val = 0; limit = 8'd9;
`ifdef CNT_THRESH_EN
        thresh = 8'd5;
`endif
        #12;
        check("reset_wrap", {27'd0, cnt_w, ovf_w, unf_w, zero_w, max_w}, {27'd0, 8'd0, 4'b0010});
        check("reset_sat",  {27'd0, cnt_s, ovf_s, unf_s, zero_s, max_s}, {27'd0, 8'd0, 4'b0010});
`ifdef CNT_THRESH_EN
        check("reset_above", {31'd0, above_w}, 32'd0);
`endif
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Async reset in the middle of a run drops the count and a pending ovf pulse.
        apply(100, mk(0, 1, 0, 0, 0, 0, 8, 9, 0, 8, 0, 0));
        apply(101, mk(0, 0, 1, 1, 0, 3, 0, 9, 0, 1, 1, 0));
        #2 arst_n = 1'b0;
        #1;
        $display("midreset: count=%0d ovf=%0b", cnt_w, ovf_w);
        check("midreset_count", {24'd0, cnt_w}, 32'd0);
        check("midreset_ovf",   {31'd0, ovf_w}, 32'd0);
        @(negedge clk);
        en = 0; inc = 0; set = 0; clr = 0;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("postreset: count=%0d ovf=%0b", cnt_w, ovf_w);
        check("postreset", {23'd0, cnt_w, ovf_w}, 32'd0);

`ifdef CNT_THRESH_EN
        apply(200, mk(0, 1, 0, 0, 0, 0, 3, 9, 0, 3, 0, 0));
        check("above_3", {31'd0, above_w}, 32'd0);
        apply(201, mk(0, 0, 1, 1, 0, 1, 0, 9, 0, 4, 0, 0));
        check("above_4", {31'd0, above_w}, 32'd0);
        apply(202, mk(0, 0, 1, 1, 0, 1, 0, 9, 0, 5, 0, 0));
        check("above_5", {31'd0, above_w}, 32'd1);
        apply(203, mk(0, 0, 1, 1, 0, 1, 0, 9, 0, 6, 0, 0));
        check("above_6", {31'd0, above_w}, 32'd1);
        #2 arst_n = 1'b0;
        #1;
        $display("thresh midreset: count=%0d above=%0b", cnt_w, above_w);
        check("above_rst", {23'd0, cnt_w, above_w}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
